// File: rtl/crypto_sched.sv
// -----------------------------------------------------------------------------
// crypto_sched
//
// Purpose:
//   Shares one PRESENT-80 block-cipher core between two requesters. A job is
//   granted from IDLE, its plaintext/key are registered towards the core, the
//   core is started, and the result is returned to the requester that owns it.
//   When both requesters are waiting, the one that was not served last wins.
//
// Configuration:
//   CRYPTO_SCHED_TIMEOUT_EN - when defined, an 8-bit counter bounds the time
//   spent waiting for the core. After TIMEOUT_CYCLES cycles in WAIT with no
//   core_done, the job ends with err=1 and ct=0. When undefined, WAIT lasts
//   until core_done and err is tied to 0.
//
// Parameters:
//   TIMEOUT_CYCLES  cycle limit for WAIT when the timeout is compiled in (2..255)
//
// Ports:
//   clk         in   single clock, rising edge
//   reset_n     in   synchronous active-low reset
//   req[1:0]    in   per-requester job request (level, held until ack[r])
//   pt0, pt1    in   64-bit plaintext of requester 0/1
//   key0, key1  in   80-bit key of requester 0/1
//   ack[1:0]    out  one-cycle pulse: job accepted, inputs captured
//   rsp_valid   out  one-cycle pulse per requester: result on ct/err
//   ct          out  ciphertext of the last completed job
//   err         out  1 = job aborted by timeout (qualified by rsp_valid)
//   owner       out  requester index of the current/last job
//   core_start  out  one-cycle start pulse to the cipher core
//   core_pt     out  registered plaintext to the core
//   core_key    out  registered key to the core
//   core_busy   in   core busy status (blocks a new grant)
//   core_done   in   core completion pulse
//   core_ct     in   core ciphertext, valid with core_done
//   dbg_state   out  current FSM state (IDLE=0, START=1, WAIT=2, RESP=3)
//
// Handshake:
//   req[r] acts as a valid that must stay high, with pt/key stable, until
//   ack[r] pulses; ack[r] is the one-cycle ready/accept and marks the cycle
//   after the inputs were captured. Dropping req[r] before ack[r] withdraws
//   the request. rsp_valid[r] is a one-cycle pulse with no back-pressure.
// -----------------------------------------------------------------------------
module crypto_sched #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  req,
  input  logic [63:0] pt0,
  input  logic [63:0] pt1,
  input  logic [79:0] key0,
  input  logic [79:0] key1,
  output logic [1:0]  ack,
  output logic [1:0]  rsp_valid,
  output logic [63:0] ct,
  output logic        err,
  output logic        owner,
  output logic        core_start,
  output logic [63:0] core_pt,
  output logic [79:0] core_key,
  input  logic        core_busy,
  input  logic        core_done,
  input  logic [63:0] core_ct,
  output logic [1:0]  dbg_state
);

  // Elaboration-time range guard on the timeout limit.
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("crypto_sched: TIMEOUT_CYCLES must be in 2..255");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  ack_q, ack_d;
  logic [1:0]  rsp_valid_q, rsp_valid_d;
  logic [63:0] ct_q, ct_d;
  logic        owner_q, owner_d;
  logic        core_start_q, core_start_d;
  logic [63:0] core_pt_q, core_pt_d;
  logic [79:0] core_key_q, core_key_d;
  logic        last_served_q, last_served_d;

`ifdef CRYPTO_SCHED_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0]  tmo_cnt_q, tmo_cnt_d;
  logic        err_q, err_d;
`endif

  // Arbitration: a lone request is granted directly; on a tie the requester
  // that was not served last wins.
  logic grant_valid;
  logic grant_idx;
  logic [1:0] grant_oh;
  logic [1:0] owner_oh;

  always_comb begin
    grant_valid = (req != 2'b00) && !core_busy;
    if (req == 2'b11) begin
      grant_idx = ~last_served_q;
    end else begin
      grant_idx = req[1];
    end
    grant_oh = grant_idx ? 2'b10 : 2'b01;
    owner_oh = owner_q ? 2'b10 : 2'b01;
  end

  // Next-state and output logic. Pulse outputs default low; everything else
  // holds its value unless a state explicitly updates it.
  always_comb begin
    state_d       = state_q;
    ack_d         = 2'b00;
    rsp_valid_d   = 2'b00;
    core_start_d  = 1'b0;
    ct_d          = ct_q;
    owner_d       = owner_q;
    core_pt_d     = core_pt_q;
    core_key_d    = core_key_q;
    last_served_d = last_served_q;
`ifdef CRYPTO_SCHED_TIMEOUT_EN
    tmo_cnt_d     = tmo_cnt_q;
    err_d         = err_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        // ack/core_start are registered here so they are visible during the
        // START cycle, one cycle after req was sampled.
        if (grant_valid) begin
          owner_d      = grant_idx;
          core_pt_d    = grant_idx ? pt1 : pt0;
          core_key_d   = grant_idx ? key1 : key0;
          ack_d        = grant_oh;
          core_start_d = 1'b1;
          state_d      = ST_START;
        end
      end

      ST_START: begin
`ifdef CRYPTO_SCHED_TIMEOUT_EN
        tmo_cnt_d = 8'd0;
`endif
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        // core_done is only honoured here; a done coinciding with the last
        // timeout cycle still counts as a normal completion.
        if (core_done) begin
          ct_d        = core_ct;
          rsp_valid_d = owner_oh;
          state_d     = ST_RESP;
`ifdef CRYPTO_SCHED_TIMEOUT_EN
          err_d       = 1'b0;
`endif
        end
`ifdef CRYPTO_SCHED_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LAST) begin
          ct_d        = 64'd0;
          err_d       = 1'b1;
          rsp_valid_d = owner_oh;
          state_d     = ST_RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
`endif
      end

      ST_RESP: begin
        last_served_d = owner_q;
        state_d       = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      ack_q         <= 2'b00;
      rsp_valid_q   <= 2'b00;
      ct_q          <= 64'd0;
      owner_q       <= 1'b0;
      core_start_q  <= 1'b0;
      core_pt_q     <= 64'd0;
      core_key_q    <= 80'd0;
      last_served_q <= 1'b1;  // requester 0 wins the first tie
`ifdef CRYPTO_SCHED_TIMEOUT_EN
      tmo_cnt_q     <= 8'd0;
      err_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      ack_q         <= ack_d;
      rsp_valid_q   <= rsp_valid_d;
      ct_q          <= ct_d;
      owner_q       <= owner_d;
      core_start_q  <= core_start_d;
      core_pt_q     <= core_pt_d;
      core_key_q    <= core_key_d;
      last_served_q <= last_served_d;
`ifdef CRYPTO_SCHED_TIMEOUT_EN
      tmo_cnt_q     <= tmo_cnt_d;
      err_q         <= err_d;
`endif
    end
  end

  assign ack        = ack_q;
  assign rsp_valid  = rsp_valid_q;
  assign ct         = ct_q;
  assign owner      = owner_q;
  assign core_start = core_start_q;
  assign core_pt    = core_pt_q;
  assign core_key   = core_key_q;
  assign dbg_state  = state_q;

`ifdef CRYPTO_SCHED_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_crypto_sched.sv
// -----------------------------------------------------------------------------
// tb_crypto_sched
//
// Bench for crypto_sched. A behavioural PRESENT-80 core answers core_start
// after a random latency; expected grants follow the round-robin rule applied
// to the request levels, and expected ciphertexts come from a PRESENT-80
// reference function.
// -----------------------------------------------------------------------------
module tb_crypto_sched;

  localparam int unsigned TO = 8;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [63:0] pt0 = '0;
  logic [63:0] pt1 = '0;
  logic [79:0] key0 = '0;
  logic [79:0] key1 = '0;
  logic        core_busy = 1'b0;
  logic        core_done = 1'b0;
  logic [63:0] core_ct = '0;

  logic [1:0]  ack;
  logic [1:0]  rsp_valid;
  logic [63:0] ct;
  logic        err;
  logic        owner;
  logic        core_start;
  logic [63:0] core_pt;
  logic [79:0] core_key;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  crypto_sched #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .pt0        (pt0),
    .pt1        (pt1),
    .key0       (key0),
    .key1       (key1),
    .ack        (ack),
    .rsp_valid  (rsp_valid),
    .ct         (ct),
    .err        (err),
    .owner      (owner),
    .core_start (core_start),
    .core_pt    (core_pt),
    .core_key   (core_key),
    .core_busy  (core_busy),
    .core_done  (core_done),
    .core_ct    (core_ct),
    .dbg_state  (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // PRESENT-80 reference
  // ---------------------------------------------------------------------------
  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: return 4'hC;  4'h1: return 4'h5;  4'h2: return 4'h6;  4'h3: return 4'hB;
      4'h4: return 4'h9;  4'h5: return 4'h0;  4'h6: return 4'hA;  4'h7: return 4'hD;
      4'h8: return 4'h3;  4'h9: return 4'hE;  4'hA: return 4'hF;  4'hB: return 4'h8;
      4'hC: return 4'h4;  4'hD: return 4'h7;  4'hE: return 4'h1;  default: return 4'h2;
    endcase
  endfunction

  function automatic logic [63:0] present80(input logic [63:0] p, input logic [79:0] k);
    logic [63:0] s;
    logic [63:0] t;
    logic [79:0] kk;
    int d;
    s  = p;
    kk = k;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ kk[79:16];
      for (int n = 0; n < 16; n++) s[4*n +: 4] = sbox(s[4*n +: 4]);
      t = '0;
      for (int i = 0; i < 64; i++) begin
        d = (i == 63) ? 63 : (i * 16) % 63;
        t[d] = s[i];
      end
      s  = t;
      kk = {kk[18:0], kk[79:19]};
      kk[79:76] = sbox(kk[79:76]);
      kk[19:15] = kk[19:15] ^ 5'(r);
    end
    return s ^ kk[79:16];
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  function automatic logic [79:0] rnd80();
    return {$urandom(), $urandom(), 16'($urandom())};
  endfunction

  // ---------------------------------------------------------------------------
  // Core model: acts 2 time units after each rising edge
  // ---------------------------------------------------------------------------
  bit core_hang = 1'b0;
  int force_lat = 0;
  int spur_req  = 0;
  int spur_seen = 0;
  int done_cyc  = -10;

  initial begin : core_model
    int          cnt;
    bit          active;
    logic [63:0] lp;
    logic [79:0] lk;
    cnt = 0; active = 1'b0; lp = '0; lk = '0;
    forever begin
      @(posedge clk);
      #2;
      core_done = 1'b0;
      if (!reset_n) begin
        active    = 1'b0;
        core_busy = 1'b0;
        cnt       = 0;
        spur_seen = spur_req;
      end else begin
        if (active) begin
          if (cnt == 0) begin
            if (!core_hang) begin
              core_done = 1'b1;
              core_ct   = present80(lp, lk);
              core_busy = 1'b0;
              active    = 1'b0;
              done_cyc  = cyc;
            end
          end else begin
            cnt--;
          end
        end else if (spur_seen != spur_req) begin
          spur_seen = spur_req;
          core_done = 1'b1;
          core_ct   = rnd64();
        end
        if (core_start) begin
          active    = 1'b1;
          core_busy = 1'b1;
          lp        = core_pt;
          lk        = core_key;
          cnt       = (force_lat > 0) ? force_lat : int'($urandom_range(2, 6));
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;
  int model_last = 1;
  logic [63:0] last_ct = '0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ack"},        128'(ack),        128'(0));
    chk({tag, "_rsp_valid"},  128'(rsp_valid),  128'(0));
    chk({tag, "_core_start"}, 128'(core_start), 128'(0));
    chk({tag, "_err"},        128'(err),        128'(0));
    chk({tag, "_owner"},      128'(owner),      128'(0));
    chk({tag, "_ct"},         128'(ct),         128'(0));
    chk({tag, "_core_pt"},    128'(core_pt),    128'(0));
    chk({tag, "_core_key"},   128'(core_key),   128'(0));
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (inputs change on falling edges)
  // ---------------------------------------------------------------------------
  task automatic do_reset(input int n, input string tag);
    @(negedge clk);
    reset_n = 1'b0;
    repeat (n) @(negedge clk);
    check_reset_vals(tag);
    reset_n = 1'b1;
    model_last = 1;
    last_ct = '0;
  endtask

  task automatic raise_req(input int r, input logic [63:0] p, input logic [79:0] k);
    if (r == 0) begin
      pt0 = p; key0 = k; req[0] = 1'b1;
    end else begin
      pt1 = p; key1 = k; req[1] = 1'b1;
    end
  endtask

  task automatic wait_ack(output int ack_c);
    ack_c = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ack != 2'b00) begin
        ack_c = cyc;
        break;
      end
    end
    chk("ack_seen", 128'(ack != 2'b00), 128'(1));
  endtask

  task automatic wait_rsp(input int limit, output int rsp_c);
    rsp_c = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) begin
        rsp_c = cyc;
        break;
      end
    end
    chk("rsp_seen", 128'(rsp_valid != 2'b00), 128'(1));
  endtask

  // One complete job. Called with the DUT idle; the expected grant comes from
  // the request levels and the requester served last.
  // other_mode: 0 = leave the other requester, 1 = raise it during WAIT,
  //             2 = randomly raise/drop it during WAIT.
  task automatic run_job(input bit drop_owner, input int other_mode,
                         output int ack_c, output int rsp_c);
    int          g;
    int          o;
    int          raise_c;
    logic [1:0]  exp_oh;
    logic [63:0] ep;
    logic [79:0] ek;
    logic [63:0] exp_ct;
    if (req == 2'b11) g = 1 - model_last;
    else              g = req[1] ? 1 : 0;
    o      = 1 - g;
    exp_oh = (g == 1) ? 2'b10 : 2'b01;
    ep     = (g == 1) ? pt1 : pt0;
    ek     = (g == 1) ? key1 : key0;
    exp_ct = present80(ep, ek);
    raise_c = cyc;

    wait_ack(ack_c);
    chk("ack_latency",     128'(ack_c - raise_c), 128'(1));
    chk("ack_grant",       128'(ack),        128'(exp_oh));
    chk("core_start_high", 128'(core_start), 128'(1));
    chk("owner",           128'(owner),      128'(g));
    chk("core_pt",         128'(core_pt),    128'(ep));
    chk("core_key",        128'(core_key),   128'(ek));
    if (drop_owner) req[g] = 1'b0;

    @(negedge clk);
    chk("ack_pulse_end",   128'(ack),        128'(0));
    chk("core_start_end",  128'(core_start), 128'(0));
    if (other_mode == 1) begin
      if (!req[o]) raise_req(o, rnd64(), rnd80());
    end else if (other_mode == 2) begin
      if (req[o]) req[o] = 1'($urandom_range(0, 1));
      else if ($urandom_range(0, 1) == 1) raise_req(o, rnd64(), rnd80());
    end

    wait_rsp(100, rsp_c);
    chk("rsp_onehot",      128'(rsp_valid),  128'(exp_oh));
    chk("rsp_ct",          128'(ct),         128'(exp_ct));
    chk("rsp_err",         128'(err),        128'(0));
    chk("rsp_latency",     128'(rsp_c - done_cyc), 128'(1));
    model_last = g;
    last_ct    = exp_ct;

    @(negedge clk);
    chk("rsp_pulse_end",   128'(rsp_valid),  128'(0));
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int ack_c;
    int rsp_c;
    int seen;

    // Reset values
    do_reset(3, "reset");

    // Single job with the all-zero known-answer vector
    raise_req(0, 64'h0, 80'h0);
    run_job(1'b1, 0, ack_c, rsp_c);
    chk("kat_zero", 128'(ct), 128'(64'h5579C1387B228445));

    // Tie from reset: requester 0 first, then requester 1
    do_reset(1, "reset2");
    raise_req(0, 64'h0, 80'h0);
    raise_req(1, 64'hFFFF_FFFF_FFFF_FFFF, 80'hFFFF_FFFF_FFFF_FFFF_FFFF);
    run_job(1'b1, 0, ack_c, rsp_c);
    chk("tie_first_ct", 128'(ct), 128'(64'h5579C1387B228445));
    run_job(1'b1, 0, ack_c, rsp_c);
    chk("tie_second_ct", 128'(ct), 128'(64'h3333DCD3213210D2));

    // Fairness: req0 held, req1 raised during WAIT, next grant goes to 1
    raise_req(0, rnd64(), rnd80());
    run_job(1'b0, 1, ack_c, rsp_c);
    run_job(1'b1, 0, ack_c, rsp_c);
    chk("fair_owner", 128'(owner), 128'(1));
    run_job(1'b1, 0, ack_c, rsp_c);

    // Randomized job mix with request changes during WAIT
    for (int it = 0; it < 40; it++) begin
      if (req == 2'b00) raise_req(int'($urandom_range(0, 1)), rnd64(), rnd80());
      run_job(1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), ack_c, rsp_c);
    end
    req = 2'b00;
    repeat (8) @(negedge clk);

    // Reset in the middle of a job: no response, then normal service
    raise_req(0, rnd64(), rnd80());
    wait_ack(ack_c);
    req[0] = 1'b0;
    do_reset(1, "midjob");
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) seen = 1;
    end
    chk("midjob_no_rsp", 128'(seen), 128'(0));
    raise_req(1, rnd64(), rnd80());
    run_job(1'b1, 0, ack_c, rsp_c);

    // Spurious core_done while idle
    spur_req++;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) seen = 1;
    end
    chk("spurious_no_rsp", 128'(seen), 128'(0));
    chk("spurious_ct_held", 128'(ct), 128'(last_ct));

    // core_done on the last allowed WAIT cycle is a normal completion
    force_lat = int'(TO) - 1;
    raise_req(0, rnd64(), rnd80());
    run_job(1'b1, 0, ack_c, rsp_c);
    chk("edge_done_timing", 128'(rsp_c - ack_c), 128'(TO + 1));
    force_lat = 0;

    // Core never completes
    core_hang = 1'b1;
    raise_req(1, rnd64(), rnd80());
    wait_ack(ack_c);
    req[1] = 1'b0;
`ifdef CRYPTO_SCHED_TIMEOUT_EN
    wait_rsp(40, rsp_c);
    chk("tmo_rsp_onehot", 128'(rsp_valid), 128'(2'b10));
    chk("tmo_err",        128'(err),       128'(1));
    chk("tmo_ct",         128'(ct),        128'(0));
    chk("tmo_timing",     128'(rsp_c - ack_c), 128'(TO + 1));
    @(negedge clk);
    chk("tmo_rsp_end",    128'(rsp_valid), 128'(0));
`else
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) seen = 1;
    end
    chk("hang_no_rsp", 128'(seen), 128'(0));
    chk("hang_err",    128'(err),  128'(0));
`endif
    core_hang = 1'b0;
    do_reset(2, "final");

    // Service resumes after recovery
    raise_req(0, rnd64(), rnd80());
    raise_req(1, rnd64(), rnd80());
    run_job(1'b1, 0, ack_c, rsp_c);
    run_job(1'b1, 0, ack_c, rsp_c);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/crypto_sched.md
CRYPTO_SCHED -- requirements
Module: crypto_sched

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64, is the cycle limit for WAIT when the timeout is compiled in (range 2..255).
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 reset_n  input  1  reset, synchronous, active-low.
REQ-004 req  input  2  per-requester job request; bit r = requester r; level, held until ack[r].
REQ-005 pt0, pt1  input  64  plaintext of requester 0/1; stable while req[r]=1.
REQ-006 key0, key1  input  80  key of requester 0/1; stable while req[r]=1.
REQ-007 ack  output  2  one-cycle pulse: job of requester r accepted and inputs captured.
REQ-008 rsp_valid  output  2  one-cycle pulse: result for requester r on ct/err.
REQ-009 ct  output  64  ciphertext of the last completed job; held until the next RESP.
REQ-010 err  output  1  qualified by rsp_valid; 1 = job aborted by timeout.
REQ-011 owner  output  1  requester index of the job in progress (or the last job).
REQ-012 core_start  output  1  one-cycle start pulse to the PRESENT-80 core.
REQ-013 core_pt  output  64  registered plaintext to the core; held from START until the next grant.
REQ-014 core_key  output  80  registered key to the core; held from START until the next grant.
REQ-015 core_busy  input  1  core busy status.
REQ-016 core_done  input  1  core completion pulse.
REQ-017 core_ct  input  64  core ciphertext; valid when core_done=1.

Function
REQ-018 States: IDLE, START, WAIT, RESP. The FSM and all outputs shall be registered.
REQ-019 IDLE: if req is nonzero and core_busy=0, grant a requester, capture its pt/key into core_pt/core_key, set owner, and go to START; otherwise stay in IDLE.
REQ-020 Arbitration: with one request, grant that requester. With both requests, grant the requester that is not last_served.
REQ-021 START (one cycle): ack[owner]=1 and core_start=1, then go to WAIT.
REQ-022 Latency: req sampled at edge t gives ack and core_start high during cycle t+1.
REQ-023 WAIT: on core_done=1, latch core_ct into ct, set err=0, and go to RESP.
REQ-024 core_done in IDLE, START or RESP shall be ignored.
REQ-025 RESP (one cycle): rsp_valid[owner]=1, last_served<=owner, then go to IDLE.
REQ-026 Result timing: core_done at edge u gives rsp_valid during cycle u+1.
REQ-027 A req deasserted before ack shall be dropped, with no ack.
REQ-028 A req still high after RESP shall be a new job, subject to round-robin.
REQ-029 Fairness: neither requester shall be granted twice in a row while the other has req=1.
REQ-030 req changes outside IDLE shall not affect the job in progress.

Reset
REQ-031 When reset_n=0 at a clock edge, go to IDLE, whatever the current state (mid-job included).
REQ-032 Reset values: ack=0, rsp_valid=0, core_start=0, err=0, owner=0, ct=0, core_pt=0, core_key=0, last_served=1 (requester 0 wins the first tie).
REQ-033 A job interrupted by reset shall produce no rsp_valid.

Configuration
REQ-034 Macro CRYPTO_SCHED_TIMEOUT_EN defined: an 8-bit counter clears on entry to WAIT and increments each WAIT cycle.
- If the counter reaches TIMEOUT_CYCLES without core_done, go to RESP with err=1 and ct=0.
- A core_done in the same cycle as the timeout shall win (err=0).
REQ-035 Macro CRYPTO_SCHED_TIMEOUT_EN undefined: WAIT lasts until core_done, with no counter; err is constant 0.

Verification
REQ-036 Single job: req=01, pt0=0, key0=0 -> ack=01 one cycle, core_start one cycle, then rsp_valid=01 with ct=5579C1387B228445, err=0.
REQ-037 Tie: req=11 from reset with pt1=FFFFFFFFFFFFFFFF, key1=FFFFFFFFFFFFFFFFFFFF -> requester 0 served first (ct=5579C1387B228445), then requester 1 (ct=3333DCD3213210D2); rsp_valid order 01, 10.
REQ-038 Fairness: req0 held high continuously and req1 raised during requester 0's WAIT -> the next grant is ack=10.
REQ-039 Reset mid-job: reset_n=0 for one cycle during WAIT -> all outputs at reset values, no rsp_valid; a following req=10 is served normally.
REQ-040 Timeout (macro defined, TIMEOUT_CYCLES=8, core model never asserts done) -> rsp_valid one cycle after WAIT cycle 8, err=1, ct=0.
- Same bench with the macro undefined -> the FSM stays in WAIT, with no rsp_valid.
REQ-041 Spurious core_done pulsed in IDLE -> no rsp_valid, and ct unchanged.
